// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA vertical stage.
package vga_timing_pkg;

    typedef enum logic [1:0] {ST_ACT, ST_FP, ST_SYNC, ST_BP} v_state_t;

    typedef logic [9:0] coord_t;

    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_pixel_coord.sv
// Column counter for the pixel generator plus per-line active-pixel overrun detect.
module vga_pixel_coord #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_active_i,
    input  logic       line_tick_i,
    output logic [9:0] pixel_x_o,
    output logic       overrun_o
);
    import vga_timing_pkg::*;

    logic   h_active_q;
    coord_t pixel_x_q, pixel_x_d;
    coord_t line_px_q, line_px_d;

    // Flags the active cycle that would push the line past H_ACTIVE pixels.
    assign overrun_o = h_active_i && (int'(line_px_q) >= H_ACTIVE);
    assign pixel_x_o = pixel_x_q;

    always_comb begin
        pixel_x_d = '0;
        if (h_active_i && h_active_q) begin
            pixel_x_d = (pixel_x_q == '1) ? pixel_x_q : pixel_x_q + 10'd1;
        end

        line_px_d = line_px_q;
        if (line_tick_i) begin
            line_px_d = '0;
        end else if (h_active_i && (line_px_q != '1)) begin
            line_px_d = line_px_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_active_q <= 1'b0;
            pixel_x_q  <= '0;
            line_px_q  <= '0;
        end else begin
            h_active_q <= h_active_i;
            pixel_x_q  <= pixel_x_d;
            line_px_q  <= line_px_d;
        end
    end

endmodule

// File: rtl/vga_vertical_timing.sv
// Vertical line counter, vsync FSM, display enable and frame/line markers,
// fed by the horizontal counter stage. All outputs registered.
module vga_vertical_timing #(
    parameter int   H_TOTAL   = vga_timing_pkg::H_TOTAL,
    parameter int   H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
    parameter int   V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP      = vga_timing_pkg::V_FP,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BP      = vga_timing_pkg::V_BP,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_count_i,
    input  logic       h_active_i,
    output logic [9:0] v_count_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic [9:0] pixel_x_o,
    output logic [9:0] pixel_y_o,
    output logic       line_end_o,
    output logic       frame_start_o,
    output logic       timing_err_o
);
    import vga_timing_pkg::*;

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    v_state_t state_q, state_d;
    coord_t   v_count_q, v_count_d;
    coord_t   pixel_y_q, pixel_y_d;
    logic     vsync_q, vsync_d;
    logic     de_q, de_d;
    logic     line_end_q;
    logic     frame_start_q, frame_start_d;
    logic     timing_err_q, timing_err_d;
    logic     line_tick, h_oor, line_overrun;

    assign line_tick = (int'(h_count_i) == H_TOTAL - 1);
    assign h_oor     = (int'(h_count_i) >= H_TOTAL);

    vga_pixel_coord #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel_coord (
        .clk         (clk),
        .reset       (reset),
        .h_active_i  (h_active_i),
        .line_tick_i (line_tick),
        .pixel_x_o   (pixel_x_o),
        .overrun_o   (line_overrun)
    );

    always_comb begin
        state_d       = state_q;
        v_count_d     = v_count_q;
        frame_start_d = 1'b0;

        if (line_tick) begin
            v_count_d = (int'(v_count_q) == V_TOTAL - 1) ? '0 : v_count_q + 10'd1;
            case (state_q)
                ST_ACT:  if (int'(v_count_q) == V_ACTIVE - 1)
                             state_d = ST_FP;
                ST_FP:   if (int'(v_count_q) == V_ACTIVE + V_FP - 1)
                             state_d = ST_SYNC;
                ST_SYNC: if (int'(v_count_q) == V_ACTIVE + V_FP + V_SYNC - 1)
                             state_d = ST_BP;
                ST_BP:   if (int'(v_count_q) == V_TOTAL - 1) begin
                             state_d       = ST_ACT;
                             frame_start_d = 1'b1;
                         end
                default: state_d = ST_ACT;
            endcase
        end

        // vsync and pixel_y follow the post-edge state so they line up with v_count_o.
        vsync_d      = (state_d == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        pixel_y_d    = (state_d == ST_ACT) ? v_count_d : '0;
        de_d         = h_active_i && (state_q == ST_ACT);
        timing_err_d = timing_err_q | h_oor | line_overrun | (h_active_i & line_tick);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ACT;
            v_count_q     <= '0;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            pixel_y_q     <= '0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_count_q     <= v_count_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pixel_y_q     <= pixel_y_d;
            line_end_q    <= line_tick;
            frame_start_q <= frame_start_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign v_count_o     = v_count_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign pixel_y_o     = pixel_y_q;
    assign line_end_o    = line_end_q;
    assign frame_start_o = frame_start_q;
    assign timing_err_o  = timing_err_q;

endmodule

// File: tb/tb_vga_vertical_timing.sv
// Directed bench for vga_vertical_timing; a VSYNC_POL=1 copy runs on the same stimulus.
module tb_vga_vertical_timing;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] h_count = '0;
    logic       h_active = 1'b0;

    logic [9:0] v_count, pixel_x, pixel_y;
    logic       vsync, de, line_end, frame_start, timing_err;
    logic [9:0] v_count_p1, pixel_x_p1, pixel_y_p1;
    logic       vsync_p1, de_p1, line_end_p1, frame_start_p1, timing_err_p1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_vertical_timing dut (
        .clk           (clk),
        .reset         (reset),
        .h_count_i     (h_count),
        .h_active_i    (h_active),
        .v_count_o     (v_count),
        .vsync_o       (vsync),
        .de_o          (de),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y),
        .line_end_o    (line_end),
        .frame_start_o (frame_start),
        .timing_err_o  (timing_err)
    );

    vga_vertical_timing #(.VSYNC_POL(1'b1)) dut_p1 (
        .clk           (clk),
        .reset         (reset),
        .h_count_i     (h_count),
        .h_active_i    (h_active),
        .v_count_o     (v_count_p1),
        .vsync_o       (vsync_p1),
        .de_o          (de_p1),
        .pixel_x_o     (pixel_x_p1),
        .pixel_y_o     (pixel_y_p1),
        .line_end_o    (line_end_p1),
        .frame_start_o (frame_start_p1),
        .timing_err_o  (timing_err_p1)
    );

    task automatic step(input logic [9:0] hc, input logic ha);
        h_count  = hc;
        h_active = ha;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        h_count  = '0;
        h_active = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (v_count !== 10'd0 || v_count_p1 !== 10'd0)
            $display("FAIL reset_vcount: got %0d/%0d expected 0", v_count, v_count_p1);
        else n_pass++;
        n_checks++;
        if (vsync !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", vsync);
        else n_pass++;
        n_checks++;
        if (vsync_p1 !== 1'b0) $display("FAIL reset_vsync_pol1: got %b expected 0", vsync_p1);
        else n_pass++;
        n_checks++;
        if ({de, pixel_x, pixel_y, line_end, frame_start, timing_err} !== 25'd0)
            $display("FAIL reset_outputs: got de=%b px=%0d py=%0d le=%b fs=%b err=%b expected all 0",
                     de, pixel_x, pixel_y, line_end, frame_start, timing_err);
        else n_pass++;
        n_checks++;
        if ({de_p1, pixel_x_p1, pixel_y_p1, line_end_p1, frame_start_p1, timing_err_p1} !== 25'd0)
            $display("FAIL reset_outputs_pol1: got de=%b px=%0d py=%0d le=%b fs=%b err=%b expected all 0",
                     de_p1, pixel_x_p1, pixel_y_p1, line_end_p1, frame_start_p1, timing_err_p1);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_first_line();
        int le_cnt = 0, de_cnt = 0, px_err = 0, exp_px = 0, last_px = -1;
        for (int h = 0; h < 800; h++) begin
            step(10'(h), (h >= 144 && h <= 783));
            if (line_end === 1'b1) le_cnt++;
            if (de === 1'b1) begin
                if (pixel_x !== 10'(exp_px) || pixel_y !== 10'd0) px_err++;
                last_px = int'(pixel_x);
                exp_px++;
                de_cnt++;
            end
        end
        n_checks++;
        if (le_cnt != 1) $display("FAIL line_end_count: got %0d expected 1", le_cnt);
        else n_pass++;
        n_checks++;
        if (de_cnt != 640) $display("FAIL de_count: got %0d expected 640", de_cnt);
        else n_pass++;
        n_checks++;
        if (px_err != 0 || last_px != 639)
            $display("FAIL pixel_x_seq: got %0d errors last=%0d expected 0 errors last=639", px_err, last_px);
        else n_pass++;
        n_checks++;
        if (v_count !== 10'd1 || line_end !== 1'b1)
            $display("FAIL first_line_vcount: got v=%0d le=%b expected v=1 le=1", v_count, line_end);
        else n_pass++;
    endtask

    // Short lines: four active cycles then the terminal count, one frame from line 1.
    task automatic test_frame();
        int  exp_v = 1;
        int  v_err = 0, vs_err = 0, fs_cnt = 0, fs_err = 0, de_err = 0, py_err = 0, px_err = 0;
        int  vs_low = 0;
        logic wrap, exp_low;
        for (int ln = 1; ln <= 524; ln++) begin
            for (int i = 0; i < 5; i++) begin
                wrap = 1'b0;
                if (i < 4) step(10'(100 + i), 1'b1);
                else begin
                    step(10'd799, 1'b0);
                    wrap  = (exp_v == 524);
                    exp_v = wrap ? 0 : exp_v + 1;
                end
                exp_low = (exp_v >= 490 && exp_v <= 491);
                if (v_count !== 10'(exp_v)) v_err++;
                if (vsync !== ~exp_low || vsync_p1 !== exp_low) vs_err++;
                if (vsync === 1'b0) vs_low++;
                if (frame_start === 1'b1) fs_cnt++;
                if (frame_start !== wrap || (wrap && line_end !== 1'b1)) fs_err++;
                if (de !== (i < 4 && exp_v < 480)) de_err++;
                if (pixel_y !== ((exp_v < 480) ? 10'(exp_v) : 10'd0)) py_err++;
                if (pixel_x !== ((i < 4) ? 10'(i) : 10'd0)) px_err++;
            end
        end
        n_checks++;
        if (v_err != 0) $display("FAIL frame_vcount: got %0d mismatching cycles expected 0", v_err);
        else n_pass++;
        n_checks++;
        if (vs_err != 0 || vs_low != 10)
            $display("FAIL frame_vsync: got %0d errors, %0d low cycles expected 0 errors, 10 low", vs_err, vs_low);
        else n_pass++;
        n_checks++;
        if (fs_cnt != 1 || fs_err != 0)
            $display("FAIL frame_start: got %0d pulses %0d errors expected 1 pulse 0 errors", fs_cnt, fs_err);
        else n_pass++;
        n_checks++;
        if (de_err != 0) $display("FAIL frame_de: got %0d errors expected 0", de_err);
        else n_pass++;
        n_checks++;
        if (py_err != 0 || px_err != 0)
            $display("FAIL frame_pixel_xy: got py_err=%0d px_err=%0d expected 0", py_err, px_err);
        else n_pass++;
        n_checks++;
        if (timing_err !== 1'b0 || v_count !== 10'd0)
            $display("FAIL frame_end_state: got err=%b v=%0d expected err=0 v=0", timing_err, v_count);
        else n_pass++;
    endtask

    task automatic test_hcount_oor();
        for (int h = 0; h < 100; h++) step(10'(h), 1'b0);
        repeat (3) step(10'd850, 1'b0);
        n_checks++;
        if (timing_err !== 1'b1 || v_count !== 10'd0 || line_end !== 1'b0)
            $display("FAIL oor_detect: got err=%b v=%0d le=%b expected err=1 v=0 le=0",
                     timing_err, v_count, line_end);
        else n_pass++;
        for (int h = 100; h < 800; h++) step(10'(h), 1'b0);
        n_checks++;
        if (timing_err !== 1'b1 || v_count !== 10'd1)
            $display("FAIL oor_recover: got err=%b v=%0d expected err=1 v=1", timing_err, v_count);
        else n_pass++;
        do_reset();
        n_checks++;
        if (timing_err !== 1'b0) $display("FAIL oor_reset_clear: got %b expected 0", timing_err);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int k = 0, err_cnt = 0, max_px = 0;
        logic ha;
        do_reset();
        for (int h = 0; h < 800; h++) begin
            ha = (h >= 50 && h <= 749);
            step(10'(h), ha);
            if (ha) begin
                k++;
                if (pixel_x !== 10'(k - 1)) err_cnt++;
            end
            if (timing_err !== (k >= 641)) err_cnt++;
            if (int'(pixel_x) > max_px) max_px = int'(pixel_x);
        end
        n_checks++;
        if (err_cnt != 0) $display("FAIL overrun_trace: got %0d errors expected 0", err_cnt);
        else n_pass++;
        n_checks++;
        if (max_px != 699 || timing_err !== 1'b1)
            $display("FAIL overrun_end: got max_px=%0d err=%b expected 699 err=1", max_px, timing_err);
        else n_pass++;
    endtask

    task automatic test_boundary();
        do_reset();
        step(10'd800, 1'b0);
        n_checks++;
        if (timing_err !== 1'b1 || v_count !== 10'd0 || line_end !== 1'b0)
            $display("FAIL hcount_800: got err=%b v=%0d le=%b expected err=1 v=0 le=0",
                     timing_err, v_count, line_end);
        else n_pass++;
        do_reset();
        step(10'd799, 1'b1);
        n_checks++;
        if (timing_err !== 1'b1 || v_count !== 10'd1 || line_end !== 1'b1)
            $display("FAIL active_on_tick: got err=%b v=%0d le=%b expected err=1 v=1 le=1",
                     timing_err, v_count, line_end);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (300) step(10'd799, 1'b0);
        for (int h = 0; h <= 200; h++) step(10'(h), 1'b1);
        n_checks++;
        if (v_count !== 10'd300 || pixel_x !== 10'd200 || de !== 1'b1 || pixel_y !== 10'd300)
            $display("FAIL mid_precond: got v=%0d px=%0d de=%b py=%0d expected 300 200 1 300",
                     v_count, pixel_x, de, pixel_y);
        else n_pass++;
        #2;
        reset    = 1'b1;
        h_count  = '0;
        h_active = 1'b0;
        #1;
        n_checks++;
        if ({v_count, pixel_x, pixel_y, de, line_end, frame_start, timing_err} !== 34'd0
            || vsync !== 1'b1 || vsync_p1 !== 1'b0)
            $display("FAIL mid_async_reset: got v=%0d px=%0d py=%0d de=%b vs=%b expected 0 0 0 0 1",
                     v_count, pixel_x, pixel_y, de, vsync);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(10'd799, 1'b0);
        n_checks++;
        if (v_count !== 10'd1 || line_end !== 1'b1)
            $display("FAIL mid_restart: got v=%0d le=%b expected v=1 le=1", v_count, line_end);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_hcount_oor();
        test_overrun();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1);
    end

endmodule
